secuenciador_linea: RTL and testbench
=====================================

SECUENCIADOR_LINEA -- requirements
Module: secuenciador_linea

Interface
REQ-001 The parameters SHALL be, one per line (name, default, meaning):
- CLK_DIV, 125, CLK cycles per half-period of head shift clock.
- STB_CYCLES, 50000, CLK cycles per heating phase.
- STEP_CYCLES, 2000, CLK cycles per half of motor step pulse.
REQ-002 CLK  input  1  system clock; the block SHALL use only this one clock, all logic on its rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to print one 384-dot line.
REQ-005 abort  input  1  synchronous cancel of the line in progress.
REQ-006 rd_data  input  8  line-buffer byte; valid one CLK cycle after rd_addr.
REQ-007 rd_addr  output  6  line-buffer byte address, 0..47.
REQ-008 busy  output  1  high while a line is in progress.
REQ-009 done  output  1  one-cycle pulse when a line completes.
REQ-010 DO  output  1  serial dot data to print head.
REQ-011 CLKimpr  output  1  print-head shift clock; head samples DO on its rising edge.
REQ-012 LATn  output  1  print-head latch, active low.
REQ-013 STB  output  6  heating strobes, one per 64-dot group, active high.
REQ-014 MOT_STEP  output  1  paper-motor step pulse.

Function
REQ-015 States SHALL be IDLE, FETCH, SHIFT, LATCH, HEAT, STEP, DONE.
REQ-016 In IDLE, start high at a CLK edge SHALL give busy=1, rd_addr=0 and state FETCH on the next cycle; start while busy SHALL be ignored.
REQ-017 FETCH SHALL wait one cycle, register rd_data into an 8-bit shift register and enter SHIFT.
REQ-018 SHIFT SHALL output 8 bits, MSB first, each with DO stable and CLKimpr low for CLK_DIV cycles, then CLKimpr high for CLK_DIV cycles.
REQ-019 After bit 0 of a byte, rd_addr SHALL increment and the block SHALL return to FETCH; after byte 47 it SHALL enter LATCH (exactly 384 CLKimpr rising edges per line).
REQ-020 LATCH SHALL hold LATn=0 for CLK_DIV cycles with CLKimpr=0 and DO=0, then release LATn=1 and enter HEAT.
REQ-021 HEAT SHALL drive strobe phases of STB_CYCLES each, with one idle cycle (STB=0) between phases; grouping is per REQ-028/029.
REQ-022 STEP SHALL drive MOT_STEP=1 for STEP_CYCLES, then 0 for STEP_CYCLES, then enter DONE.
REQ-023 DONE SHALL pulse done=1 for one cycle, drop busy in the same cycle and return to IDLE.
REQ-024 abort high in any non-IDLE state SHALL, on the next cycle, force IDLE, busy=0, STB=0, MOT_STEP=0, CLKimpr=0, LATn=1, DO=0 and rd_addr=0, with no done pulse; abort has priority over start.
REQ-025 STB SHALL never be nonzero while LATn=0 or CLKimpr toggles, and MOT_STEP SHALL never be high while STB is nonzero.
REQ-026 All counters SHALL be sized for parameter maxima without wrap; rd_addr SHALL never exceed 47.

Reset
REQ-027 While RST_N=0, state SHALL be IDLE and outputs SHALL be DO=0, CLKimpr=0, LATn=1, STB=0, MOT_STEP=0, busy=0, done=0, rd_addr=0; reset mid-line SHALL discard the line without a done pulse.

Configuration
REQ-028 With HEAT_DUAL_EN defined, HEAT SHALL run 3 phases: STB=6'b000011, 6'b001100, 6'b110000.
REQ-029 Without HEAT_DUAL_EN, HEAT SHALL run 6 phases, STB one-hot from bit 0 to bit 5.

Verification
REQ-030 The bench SHALL run with CLK_DIV=2, STB_CYCLES=10 and STEP_CYCLES=4, covering the scenarios below.
REQ-031 Buffer byte n = n, start pulse -> 384 CLKimpr rising edges, DO bitstream equal to bytes 0..47 MSB-first, one LATn low pulse of 2 cycles, then done.
REQ-032 HEAT_DUAL_EN off -> 6 STB one-hot pulses of 10 cycles each; HEAT_DUAL_EN on -> 3 pair pulses 000011, 001100, 110000.
REQ-033 abort asserted after the 100th CLKimpr rising edge -> all outputs at idle values next cycle, no done pulse; a new start then produces a full 384-edge line.
REQ-034 start held high for a whole line -> exactly one line per IDLE entry, with done pulsing once per line.
REQ-035 RST_N low during HEAT -> STB=0 immediately (asynchronously), busy=0; MOT_STEP is never high during any strobe.

Source files
------------

// File: rtl/secuenciador_linea.sv
// Thermal print-head line sequencer: fetches 48 bytes, shifts 384 dots, latches, heats, steps paper.
// Optional macro HEAT_DUAL_EN: heat in 3 paired-strobe phases instead of 6 single-strobe phases.
module secuenciador_linea #(
  parameter int CLK_DIV     = 125,
  parameter int STB_CYCLES  = 50000,
  parameter int STEP_CYCLES = 2000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] rd_data,
  output logic [5:0] rd_addr,
  output logic       busy,
  output logic       done,
  output logic       DO,
  output logic       CLKimpr,
  output logic       LATn,
  output logic [5:0] STB,
  output logic       MOT_STEP
);

  localparam int CMAX0 = (CLK_DIV > STB_CYCLES) ? CLK_DIV : STB_CYCLES;
  localparam int CMAX  = (CMAX0 > STEP_CYCLES) ? CMAX0 : STEP_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_L = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] STB_L = CW'(STB_CYCLES - 1);
  localparam logic [CW-1:0] STP_L = CW'(STEP_CYCLES - 1);
`ifdef HEAT_DUAL_EN
  localparam int NPH = 3;
`else
  localparam int NPH = 6;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, HEAT, STEP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;  // FETCH: wait done, SHIFT/STEP: second half, HEAT: gap cycle
  logic [2:0]    bit_q, bit_d;
  logic [5:0]    addr_q, addr_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    ph_q, ph_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      addr_q  <= '0;
      sh_q    <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    sh_d    = sh_q;
    ph_d    = ph_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        addr_d  = '0;
        cnt_d   = '0;
        half_d  = 1'b0;
        bit_d   = '0;
      end
      // rd_data lags rd_addr by one cycle, so capture on the second FETCH cycle
      FETCH: if (!half_q) half_d = 1'b1;
      else begin
        half_d  = 1'b0;
        sh_d    = rd_data;
        bit_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: if (cnt_q == DIV_L) begin
        cnt_d = '0;
        if (!half_q) half_d = 1'b1;
        else begin
          half_d = 1'b0;
          if (bit_q == 3'd7) begin
            if (addr_q == 6'd47) state_d = LATCH;
            else begin
              addr_d  = addr_q + 6'd1;
              state_d = FETCH;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
          end
        end
      end else cnt_d = cnt_q + 1'b1;
      LATCH: if (cnt_q == DIV_L) begin
        cnt_d   = '0;
        half_d  = 1'b0;
        ph_d    = '0;
        state_d = HEAT;
      end else cnt_d = cnt_q + 1'b1;
      HEAT: if (half_q) begin
        half_d = 1'b0;
        ph_d   = ph_q + 3'd1;
        cnt_d  = '0;
      end else if (cnt_q == STB_L) begin
        cnt_d = '0;
        if (ph_q == 3'(NPH - 1)) state_d = STEP;
        else half_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      STEP: if (cnt_q == STP_L) begin
        cnt_d = '0;
        if (!half_q) half_d = 1'b1;
        else begin
          half_d  = 1'b0;
          state_d = DONE;
        end
      end else cnt_d = cnt_q + 1'b1;
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      addr_d  = '0;
      cnt_d   = '0;
      half_d  = 1'b0;
    end
  end

  // Outputs decode from state only, so async reset forces idle values immediately
  always_comb begin
    rd_addr  = addr_q;
    busy     = (state_q != IDLE) && (state_q != DONE);
    done     = (state_q == DONE);
    DO       = (state_q == SHIFT) ? sh_q[7] : 1'b0;
    CLKimpr  = (state_q == SHIFT) && half_q;
    LATn     = (state_q != LATCH);
    MOT_STEP = (state_q == STEP) && !half_q;
    STB      = '0;
    if (state_q == HEAT && !half_q) begin
`ifdef HEAT_DUAL_EN
      STB = 6'b000011 << {ph_q[1:0], 1'b0};
`else
      STB = 6'b000001 << ph_q;
`endif
    end
  end

endmodule

// File: tb/tb_secuenciador_linea.sv
// Directed bench for secuenciador_linea with scoreboard queues for dot bits and strobe phases.
module tb_secuenciador_linea;
  localparam int CD = 2, SC = 10, SP = 4;
`ifdef HEAT_DUAL_EN
  localparam int NPH = 3;
`else
  localparam int NPH = 6;
`endif

  logic       CLK = 1'b0, RST_N = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] rd_data = 8'd0;
  logic [5:0] rd_addr, STB;
  logic       busy, done, DO, CLKimpr, LATn, MOT_STEP;

  secuenciador_linea #(.CLK_DIV(CD), .STB_CYCLES(SC), .STEP_CYCLES(SP)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .rd_data(rd_data),
    .rd_addr(rd_addr), .busy(busy), .done(done), .DO(DO), .CLKimpr(CLKimpr),
    .LATn(LATn), .STB(STB), .MOT_STEP(MOT_STEP));

  always #5 CLK = ~CLK;

  // Line buffer: byte n holds value n, one-cycle read latency
  always @(posedge CLK) rd_data <= {2'b00, rd_addr};

  int n_chk = 0, n_fail = 0;
  int edges = 0, n_lat = 0, n_stb = 0, n_done = 0;
  logic       exp_bits[$];
  logic [5:0] exp_stb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] pat(input int p);
    logic [5:0] v;
`ifdef HEAT_DUAL_EN
    v = 6'b000011;
    return v << (2 * p);
`else
    v = 6'b000001;
    return v << p;
`endif
  endfunction

  task automatic push_line();
    for (int b = 0; b < 48; b++)
      for (int i = 7; i >= 0; i--) exp_bits.push_back(((b >> i) & 1) != 0);
    for (int p = 0; p < NPH; p++) exp_stb.push_back(pat(p));
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  logic       ck_prev = 1'b0, lat_prev = 1'b1, done_prev = 1'b0;
  logic [5:0] stb_prev = '0, stb_pat = '0;
  int         lat_len = 0, stb_len = 0, mot_len = 0;
  always @(negedge CLK) begin
    if (CLKimpr && !ck_prev) begin
      edges++;
      chk("addr_range", 32'(rd_addr <= 6'd47), 32'd1);
      if (exp_bits.size() > 0) chk("do_bit", 32'(DO), 32'(exp_bits.pop_front()));
      else chk("extra_clk_edge", 32'(exp_bits.size()), 32'd1);
    end
    if (STB != 0) chk("stb_safe", 32'({LATn, CLKimpr, MOT_STEP}), 32'b100);
    if (done) begin
      n_done++;
      chk("done_width", 32'(done_prev), 32'd0);
    end
    if (!LATn) lat_len++;
    else if (!lat_prev) begin
      n_lat++;
      chk("lat_width", 32'(lat_len), 32'(CD));
      lat_len = 0;
    end
    if (MOT_STEP) mot_len++;
    else if (mot_len != 0) begin
      if (RST_N) chk("mot_width", 32'(mot_len), 32'(SP));
      mot_len = 0;
    end
    if (STB != 0) begin
      if (stb_prev == 0) begin
        stb_pat = STB;
        stb_len = 1;
      end else begin
        if (STB != stb_pat) chk("stb_stable", 32'(STB), 32'(stb_pat));
        stb_len++;
      end
    end else if (stb_prev != 0 && RST_N) begin
      n_stb++;
      chk("stb_width", 32'(stb_len), 32'(SC));
      if (exp_stb.size() > 0) chk("stb_pattern", 32'(stb_pat), 32'(exp_stb.pop_front()));
      else chk("extra_stb", 32'(exp_stb.size()), 32'd1);
    end
    ck_prev = CLKimpr; lat_prev = LATn; done_prev = done; stb_prev = STB;
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_DO"}, 32'(DO), 32'd0);
    chk({tag, "_CLKimpr"}, 32'(CLKimpr), 32'd0);
    chk({tag, "_LATn"}, 32'(LATn), 32'd1);
    chk({tag, "_STB"}, 32'(STB), 32'd0);
    chk({tag, "_MOT"}, 32'(MOT_STEP), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_addr"}, 32'(rd_addr), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_line(input string tag);
    int be, bd, bl, bs;
    be = edges; bd = n_done; bl = n_lat; bs = n_stb;
    push_line();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_addr_start"}, 32'(rd_addr), 32'd0);
    wait_done(5000);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    @(posedge CLK); #1;
    chk({tag, "_edges"}, 32'(edges - be), 32'd384);
    chk({tag, "_lat_pulses"}, 32'(n_lat - bl), 32'd1);
    chk({tag, "_stb_pulses"}, 32'(n_stb - bs), 32'(NPH));
    chk({tag, "_done_cnt"}, 32'(n_done - bd), 32'd1);
    chk({tag, "_bits_left"}, 32'(exp_bits.size()), 32'd0);
    chk({tag, "_stb_left"}, 32'(exp_stb.size()), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, be, bd, bs;
    repeat (3) @(posedge CLK);
    #1;
    chk_idle("reset");
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    run_line("line1");

    // Abort after the 100th head clock edge
    be = edges;
    push_line();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    k = 0;
    while (edges - be < 100 && k < 3000) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("edge100_timeout", 32'(edges - be), 32'd100);
    abort = 1'b1;
    start = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    start = 1'b0;
    chk_idle("abort");
    exp_bits.delete();
    exp_stb.delete();
    bd = n_done;
    repeat (20) @(posedge CLK);
    #1;
    chk("abort_no_done", 32'(n_done - bd), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    run_line("after_abort");

    // start held high across two lines
    be = edges; bd = n_done; bs = n_stb;
    push_line();
    push_line();
    start = 1'b1;
    wait_done(5000);
    @(posedge CLK); #1;
    chk("held_idle_entry", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    chk("held_restart", 32'(busy), 32'd1);
    wait_done(5000);
    start = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    chk("held_done_cnt", 32'(n_done - bd), 32'd2);
    chk("held_edges", 32'(edges - be), 32'd768);
    chk("held_stb_pulses", 32'(n_stb - bs), 32'(2 * NPH));
    chk("held_busy_end", 32'(busy), 32'd0);
    chk("held_bits_left", 32'(exp_bits.size()), 32'd0);

    // Reset asserted mid-HEAT
    push_line();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    k = 0;
    while (STB == 0 && k < 3000) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("heat_timeout", 32'(STB != 0), 32'd1);
    repeat (3) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_stb", 32'(STB), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mot", 32'(MOT_STEP), 32'd0);
    chk("rst_latn", 32'(LATn), 32'd1);
    exp_bits.delete();
    exp_stb.delete();
    bd = n_done;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    chk("rst_no_done", 32'(n_done - bd), 32'd0);
    chk_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
